// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Half-period values H give H+1 input cycles per output half-period.
package clk_div_pkg;

  localparam int CNT_W_DEF   = 27;
  localparam int DEF_DIV_DEF = 25000000;

  // Half-period values for a 50 MHz board clock.
  localparam int HP_1HZ  = 24999999;
  localparam int HP_4HZ  = 6249999;
  localparam int HP_8HZ  = 3124999;
  localparam int HP_16HZ = 1562499;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active and staged divisor,
// square-wave output and a rising-edge tick strobe.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RST_HP = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hp;
  logic [CNT_W-1:0] nxt;
  logic             at_bound;

  assign at_bound = (cnt == hp);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt     <= '0;
      hp      <= RST_HP;
      nxt     <= RST_HP;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (!en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
      end else if (at_bound) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Staged divisor only lands where no half-period is in progress.
      if (pending && (!en || at_bound)) begin
        hp      <= nxt;
        pending <= 1'b0;
      end

      // wr is only issued while pending is low, so it never races the swap.
      if (wr) begin
        nxt     <= wr_div;
        pending <= 1'b1;
      end
    end
  end

  a_cnt_bounded : assert property (@(posedge clk_in) disable iff (rst) cnt <= hp);
  a_wr_not_pend : assert property (@(posedge clk_in) disable iff (rst) wr |-> !pending);
  a_tick_high   : assert property (@(posedge clk_in) disable iff (rst) tick |-> clk_out);

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NCH independent channels
// sharing one divisor-load port.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int  NCH     = 4,
  parameter int  CNT_W   = CNT_W_DEF,
  parameter int  DEF_DIV = DEF_DIV_DEF,
  localparam int CH_W    = ch_width(NCH)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             ld_valid,
  input  logic [CH_W-1:0]  ld_ch,
  input  logic [CNT_W-1:0] ld_div,
  output logic             ld_ready,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pending
);

  logic [NCH-1:0] wr;

  // Load handshake: a transfer happens on a clock edge where ld_valid and
  // ld_ready are both high; ld_ready never depends on ld_valid, and the
  // requester keeps ld_valid, ld_ch and ld_div stable until the transfer.
  always_comb begin
    ld_ready = 1'b0;
    wr       = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ld_ch == CH_W'(i)) begin
        ld_ready = !pending[i];
        wr[i]    = ld_valid && !pending[i];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en[g]),
      .wr      (wr[g]),
      .wr_div  (ld_div),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end

endmodule
